// File: rtl/ho_tsm_prng_pkg.sv
// Shared HO-TSM constants and types: randomness width, LFSR geometry, PRNG FSM states.
package ho_tsm_prng_pkg;

   // Width of the fresh-randomness bus feeding the first-order time-sharing stage.
   localparam int unsigned TSM_RAND_W = 19;

   // Fibonacci LFSR x^127 + x + 1: new bit = S[TAP_A] ^ S[TAP_B], shifted in at the top.
   localparam int unsigned LFSR_LEN   = 127;
   localparam int unsigned LFSR_TAP_A = 0;
   localparam int unsigned LFSR_TAP_B = 1;

   // Seed is delivered as four 32-bit words; the top word only contributes 31 bits.
   localparam int unsigned SEED_W     = 32;
   localparam int unsigned SEED_WORDS = 4;
   localparam int unsigned SEED_TOP_W = LFSR_LEN - (SEED_WORDS - 1) * SEED_W;

   typedef logic [LFSR_LEN-1:0] lfsr_state_t;
   typedef logic [TSM_RAND_W:1] rand_batch_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLoad   = 2'd1,
      StWarmup = 2'd2,
      StRun    = 2'd3
   } prng_state_e;

   // An all-zero LFSR is a fixed point; kick it onto the maximal cycle by setting S[0].
   function automatic lfsr_state_t zero_guard(input lfsr_state_t s);
      lfsr_state_t r;
      r = s;
      if (s == '0) begin
         r[0] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ho_tsm_prng_if.sv
// Seed handshake and randomness delivery bundle between the PRNG and its user.
interface ho_tsm_prng_if;
   import ho_tsm_prng_pkg::*;

   logic [SEED_W-1:0] seed_data;
   logic              seed_valid;
   logic              seed_ready;
   logic              rand_en;
   rand_batch_t       PRNG_rand_output;
   logic              rand_valid;

   // Seeder / randomness consumer side.
   modport master (
      output seed_data,
      output seed_valid,
      output rand_en,
      input  seed_ready,
      input  PRNG_rand_output,
      input  rand_valid
   );

   // PRNG side.
   modport slave (
      input  seed_data,
      input  seed_valid,
      input  rand_en,
      output seed_ready,
      output PRNG_rand_output,
      output rand_valid
   );

endinterface

// File: rtl/ho_tsm_lfsr_batch.sv
// Combinational 19-step unroll of the x^127 + x + 1 Fibonacci LFSR.
// With taps at 0 and 1 and only 19 steps, every new bit is a single XOR of pre-batch state.
module ho_tsm_lfsr_batch
   import ho_tsm_prng_pkg::*;
(
   input  lfsr_state_t state_i,
   output lfsr_state_t state_o,
   output rand_batch_t rand_o
);

   logic [TSM_RAND_W-1:0] new_bits;

   // Bit j is produced at step j+1; after j steps the taps sit at S[j+TAP_A] and S[j+TAP_B].
   always_comb begin
      new_bits = '0;
      for (int unsigned j = 0; j < TSM_RAND_W; j++) begin
         new_bits[j] = state_i[j + LFSR_TAP_A] ^ state_i[j + LFSR_TAP_B];
      end
   end

   // Shift out 19 oldest bits; the new bits enter at the top in generation order.
   always_comb begin
      state_o = '0;
      rand_o  = '0;
      state_o[LFSR_LEN-TSM_RAND_W-1:0]        = state_i[LFSR_LEN-1:TSM_RAND_W];
      state_o[LFSR_LEN-1:LFSR_LEN-TSM_RAND_W] = new_bits;
      for (int unsigned k = 1; k <= TSM_RAND_W; k++) begin
         rand_o[k] = new_bits[k-1];
      end
   end

endmodule

// File: rtl/ho_tsm_prng.sv
// HO-TSM fresh-randomness source: seeded 127-bit LFSR, mandatory warm-up, 19 bits per clock.
module ho_tsm_prng
   import ho_tsm_prng_pkg::*;
#(
   // Batches run after seeding before output is valid; keep >= 7 so >= 127 steps mix the seed.
   parameter int unsigned WARMUP_BATCHES = 8
) (
   input  logic         clk,
   input  logic         rst,
   ho_tsm_prng_if.slave prng_if
);

   localparam int unsigned       CntW      = $clog2(WARMUP_BATCHES);
   localparam logic [CntW-1:0]   LastBatch = CntW'(WARMUP_BATCHES - 1);

   prng_state_e     state_q, state_d;
   logic [1:0]      word_cnt_q, word_cnt_d;
   logic [CntW-1:0] batch_cnt_q, batch_cnt_d;
   lfsr_state_t     s_q, s_d;
   rand_batch_t     out_q, out_d;

   lfsr_state_t     batch_state;
   rand_batch_t     batch_rand;
   logic            seed_ready;
   logic            seed_fire;

   ho_tsm_lfsr_batch u_batch (
      .state_i (s_q),
      .state_o (batch_state),
      .rand_o  (batch_rand)
   );

   // Seed words are refused only while warm-up is mixing the state.
   assign seed_ready = (state_q != StWarmup);
   assign seed_fire  = prng_if.seed_valid & seed_ready;

   assign prng_if.seed_ready       = seed_ready;
   assign prng_if.PRNG_rand_output = out_q;
   assign prng_if.rand_valid       = (state_q == StRun);

   // Next-state: seed assembly, warm-up batch counting and consumer-paced batches.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      batch_cnt_d = batch_cnt_q;
      s_d         = s_q;
      out_d       = out_q;

      case (state_q)
         StIdle, StRun: begin
            // A handshake here always carries word 0; a reseed wins over rand_en.
            if (seed_fire) begin
               s_d[SEED_W-1:0] = prng_if.seed_data;
               word_cnt_d      = 2'd1;
               state_d         = StLoad;
            end else if ((state_q == StRun) && prng_if.rand_en) begin
               s_d   = batch_state;
               out_d = batch_rand;
            end
         end

         StLoad: begin
            if (seed_fire) begin
               word_cnt_d = word_cnt_q + 2'd1;
               case (word_cnt_q)
                  2'd0: s_d[SEED_W-1:0]          = prng_if.seed_data;
                  2'd1: s_d[2*SEED_W-1:SEED_W]   = prng_if.seed_data;
                  2'd2: s_d[3*SEED_W-1:2*SEED_W] = prng_if.seed_data;
                  default: begin
                     // Top word: bit 31 has no home in a 127-bit state and is dropped.
                     s_d = zero_guard({prng_if.seed_data[SEED_TOP_W-1:0],
                                       s_q[3*SEED_W-1:0]});
                     batch_cnt_d = '0;
                     state_d     = StWarmup;
                  end
               endcase
            end
         end

         StWarmup: begin
            s_d         = batch_state;
            out_d       = batch_rand;
            batch_cnt_d = batch_cnt_q + 1'b1;
            if (batch_cnt_q == LastBatch) begin
               state_d = StRun;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State registers; reset discards any partially loaded seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         word_cnt_q  <= 2'd0;
         batch_cnt_q <= '0;
         s_q         <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         batch_cnt_q <= batch_cnt_d;
         s_q         <= s_d;
         out_q       <= out_d;
      end
   end

endmodule

// File: tb/tb_ho_tsm_prng.sv
// Scoreboard bench for ho_tsm_prng against a bit-serial x^127 + x + 1 reference.
module tb_ho_tsm_prng;
   import ho_tsm_prng_pkg::*;

   localparam int unsigned WB = 8;

   logic clk = 1'b0;
   logic rst;

   ho_tsm_prng_if bus ();

   ho_tsm_prng #(
      .WARMUP_BATCHES (WB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .prng_if (bus)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   rand_batch_t  exp_q[$];
   rand_batch_t  mon_exp;

   // Reference model state: one bit per step, S[0] oldest.
   logic [126:0] m_s;
   rand_batch_t  m_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h, t=%0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_batch();
      logic nb;
      for (int k = 1; k <= 19; k++) begin
         nb       = m_s[0] ^ m_s[1];
         m_s      = {nb, m_s[126:1]};
         m_out[k] = nb;
      end
   endtask

   task automatic model_word(input int idx, input logic [31:0] w);
      case (idx)
         0: m_s[31:0]  = w;
         1: m_s[63:32] = w;
         2: m_s[95:64] = w;
         default: begin
            m_s[126:96] = w[30:0];
            if (m_s == '0) m_s[0] = 1'b1;
         end
      endcase
   endtask

   // Four-word seed then warm-up; optionally leaves seed_valid high with hold_word offered.
   task automatic seed4(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] w3, input logic hold, input logic [31:0] hold_word);
      logic [31:0] w [4];
      w = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
         bus.seed_valid = 1'b1;
         bus.seed_data  = w[i];
         bus.rand_en    = (i != 0);
         tick();
         model_word(i, w[i]);
         check("load_valid_low", 32'(bus.rand_valid), 32'd0);
         check("load_out_held", 32'(bus.PRNG_rand_output), 32'(m_out));
         check("load_seed_ready", 32'(bus.seed_ready), 32'(i != 3));
      end
      bus.seed_valid = hold;
      bus.seed_data  = hold_word;
      for (int unsigned b = 1; b <= WB; b++) begin
         tick();
         model_batch();
         if (b == WB) exp_q.push_back(m_out);
         check("warmup_out", 32'(bus.PRNG_rand_output), 32'(m_out));
         check("warmup_valid", 32'(bus.rand_valid), 32'(b == WB));
         check("warmup_seed_ready", 32'(bus.seed_ready), 32'(b == WB));
      end
   endtask

   task automatic run(input int n, input logic en);
      for (int i = 0; i < n; i++) begin
         bus.rand_en = en;
         tick();
         if (en) model_batch();
         exp_q.push_back(m_out);
         check("run_valid", 32'(bus.rand_valid), 32'd1);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(bus.rand_valid), 32'd0);
      check({tag, "_out"}, 32'(bus.PRNG_rand_output), 32'd0);
      check({tag, "_seed_ready"}, 32'(bus.seed_ready), 32'd1);
   endtask

   // Monitor: every valid cycle must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.rand_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: got output %h with no batch expected, t=%0t",
                     bus.PRNG_rand_output, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.PRNG_rand_output !== mon_exp) begin
               n_fail++;
               $display("FAIL batch: got %h, required %h, t=%0t",
                        bus.PRNG_rand_output, mon_exp, $time);
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      bus.seed_valid = 1'b0;
      bus.seed_data  = '0;
      bus.rand_en    = 1'b0;
      m_s            = '0;
      m_out          = '0;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");

      // Single-bit seed: first valid batch (steps 134..152) is all zero.
      seed4(32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("first_out_seed1", 32'(bus.PRNG_rand_output), 32'h0);
      run(1000, 1'b1);

      // Stall then resume with no skipped batch.
      run(5, 1'b0);
      run(20, 1'b1);

      // Reseed from RUN; bit 31 of the top word is dropped.
      seed4(32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0);
      run(50, 1'b1);

      // All-zero seed is guarded into the single-bit seed stream.
      seed4(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      check("first_out_seed0", 32'(bus.PRNG_rand_output), 32'h0);
      run(40, 1'b1);

      // Reset after two seed words.
      bus.rand_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.seed_valid = 1'b1;
         bus.seed_data  = 32'h5555_0000 + 32'(i);
         tick();
         check("partial_valid_low", 32'(bus.rand_valid), 32'd0);
      end
      bus.seed_valid = 1'b0;
      rst            = 1'b1;
      tick();
      rst   = 1'b0;
      m_s   = '0;
      m_out = '0;
      check_idle("midload_reset");
      seed4(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF, 1'b0, 32'h0);
      run(30, 1'b1);

      // seed_valid held through warm-up; accepted in the first RUN cycle as a reseed.
      seed4(32'hC3C3_C3C3, 32'h3C3C_3C3C, 32'h55AA_55AA, 32'h7FFF_FFFF, 1'b1, 32'h1357_9BDF);
      seed4(32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 32'h8000_0000, 1'b0, 32'h0);
      run(30, 1'b1);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
